// File: rtl/gate_bist.sv
// gate_bist: exhaustive sweep engine for small combinational gates.
// Drives every input vector, compares the response, tallies mismatches.
module gate_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             resp,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] first_fail,
  output logic             fail_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [3:0] SET_Q = 4'(SETTLE);
  localparam logic [1:0] FIRST = (SETTLE > 0) ? HOLD : CHECK;

  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] mode_q;
  logic       expect_v;
  logic       mism;
  logic       last;

  // expected gate output for the current vector under the latched function
  always_comb begin
    expect_v = 1'b0;
    unique case (1'b1)
      mode_q == 2'b00: expect_v = ~&stim;
      mode_q == 2'b01: expect_v = &stim;
      mode_q == 2'b10: expect_v = ~|stim;
      mode_q == 2'b11: expect_v = |stim;
    endcase
  end

  assign mism = (resp !== expect_v);
  assign last = &stim;

  // sweep sequencing, scoring and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FIRST;
            cnt        <= SET_Q;
            stim       <= '0;
            mode_q     <= mode;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt <= 4'd1) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (mism) begin
              if (err_cnt != '1)
                err_cnt <= err_cnt + ERRW'(1);
              if (!fail_valid) begin
                first_fail <= stim;
                fail_valid <= 1'b1;
              end
            end
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= !fail_valid && !mism;
            end else begin
              stim  <= stim + WIDTH'(1);
              state <= FIRST;
              cnt   <= SET_Q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: two gate_bist configurations against an elapsed-time model.
// Directed scenarios followed by randomized sweeps with faults and aborts.
module tb_gate_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start_a, abort_a, resp_a;
  logic [1:0] mode_a, stim_a, ff_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [7:0] err_a;

  logic       start_b, abort_b, resp_b;
  logic [1:0] mode_b;
  logic [2:0] stim_b, ff_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [1:0] err_b;

  int checks = 0;
  int failures = 0;

  int WW[2]  = '{2, 3};
  int SS[2]  = '{1, 0};
  int SAT[2] = '{255, 3};

  int gk[2], stk[2], fen[2], fvec[2];

  int m_act[2], m_el[2], m_mode[2], m_stim[2];
  int m_busy[2], m_done[2], m_pass[2], m_err[2], m_ff[2], m_fv[2];

  function automatic bit fn(int kind, int v, int w);
    int all;
    all = (1 << w) - 1;
    case (kind)
      0: return !(v == all);
      1: return v == all;
      2: return !(v != 0);
      default: return v != 0;
    endcase
  endfunction

  function automatic bit gfun(int kind, int s, int fe, int fv, int v, int w);
    bit r;
    r = fn(kind, v, w);
    if (fe != 0 && v == fv) r = !r;
    if (s == 1) r = 1'b1;
    if (s == 2) r = 1'b0;
    return r;
  endfunction

  assign resp_a = gfun(gk[0], stk[0], fen[0], fvec[0], int'(stim_a), 2);
  assign resp_b = gfun(gk[1], stk[1], fen[1], fvec[1], int'(stim_b), 3);

  gate_bist #(.WIDTH(2), .SETTLE(1), .ERRW(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .mode(mode_a), .resp(resp_a), .stim(stim_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail(ff_a), .fail_valid(fv_a)
  );

  gate_bist #(.WIDTH(3), .SETTLE(0), .ERRW(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .mode(mode_b), .resp(resp_b), .stim(stim_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail(ff_b), .fail_valid(fv_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: sweep position derived from cycles elapsed since start
  task automatic upd(int n, bit st, bit ab, int md);
    int i;
    m_done[n] = 0;
    if (rst) begin
      m_act[n] = 0; m_el[n] = 0; m_mode[n] = 0; m_stim[n] = 0;
      m_busy[n] = 0; m_pass[n] = 0; m_err[n] = 0;
      m_ff[n] = 0; m_fv[n] = 0;
    end else if (m_act[n] == 0) begin
      if (st) begin
        m_act[n] = 1; m_el[n] = 0; m_mode[n] = md; m_stim[n] = 0;
        m_busy[n] = 1; m_pass[n] = 0; m_err[n] = 0;
        m_ff[n] = 0; m_fv[n] = 0;
      end
    end else if (ab) begin
      m_act[n] = 0;
      m_busy[n] = 0;
    end else begin
      m_el[n]++;
      if (m_el[n] % (SS[n] + 1) == 0) begin
        i = m_el[n] / (SS[n] + 1) - 1;
        if (gfun(gk[n], stk[n], fen[n], fvec[n], i, WW[n]) !=
            fn(m_mode[n], i, WW[n])) begin
          if (m_err[n] < SAT[n]) m_err[n]++;
          if (m_fv[n] == 0) begin
            m_ff[n] = i;
            m_fv[n] = 1;
          end
        end
        if (i == (1 << WW[n]) - 1) begin
          m_done[n] = 1;
          m_busy[n] = 0;
          m_pass[n] = (m_fv[n] == 0) ? 1 : 0;
          m_act[n] = 0;
        end else begin
          m_stim[n] = i + 1;
        end
      end
    end
  endtask

  // per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    upd(0, start_a, abort_a, int'(mode_a));
    upd(1, start_b, abort_b, int'(mode_b));
    #1;
    chk("a.stim", 32'(stim_a), m_stim[0]);
    chk("a.busy", 32'(busy_a), m_busy[0]);
    chk("a.done", 32'(done_a), m_done[0]);
    chk("a.pass", 32'(pass_a), m_pass[0]);
    chk("a.err", 32'(err_a), m_err[0]);
    chk("a.ff", 32'(ff_a), m_ff[0]);
    chk("a.fv", 32'(fv_a), m_fv[0]);
    chk("b.stim", 32'(stim_b), m_stim[1]);
    chk("b.busy", 32'(busy_b), m_busy[1]);
    chk("b.done", 32'(done_b), m_done[1]);
    chk("b.pass", 32'(pass_b), m_pass[1]);
    chk("b.err", 32'(err_b), m_err[1]);
    chk("b.ff", 32'(ff_b), m_ff[1]);
    chk("b.fv", 32'(fv_b), m_fv[1]);
  end

  task automatic start_run(int n, int md);
    @(negedge clk);
    if (n == 0) begin start_a = 1'b1; mode_a = 2'(md); end
    else begin start_b = 1'b1; mode_b = 2'(md); end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(int n, output int c);
    c = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      c++;
      if ((n == 0 && done_a) || (n == 1 && done_b)) return;
    end
    chk("wait_done.timeout", 0, 1);
  endtask

  initial begin
    int c, nd, n, ab_at;
    rst = 1'b1;
    start_a = 0; abort_a = 0; mode_a = 0;
    start_b = 0; abort_b = 0; mode_b = 0;
    for (int k = 0; k < 2; k++) begin
      gk[k] = 0; stk[k] = 0; fen[k] = 0; fvec[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.pass", 32'(pass_a), 0);
    chk("rst.err", 32'(err_a), 0);

    // good NAND, standard sweep
    start_run(0, 0);
    wait_done(0, c);
    chk("std.latency", c, 8);
    chk("std.pass", 32'(pass_a), 1);
    chk("std.err", 32'(err_a), 0);
    chk("std.fv", 32'(fv_a), 0);

    // stuck-at-1 output
    stk[0] = 1;
    start_run(0, 0);
    wait_done(0, c);
    chk("stuck.err", 32'(err_a), 1);
    chk("stuck.ff", 32'(ff_a), 3);
    chk("stuck.fv", 32'(fv_a), 1);
    chk("stuck.pass", 32'(pass_a), 0);
    stk[0] = 0;

    // wrong function, then rerun
    start_run(0, 1);
    wait_done(0, c);
    chk("wrong.err", 32'(err_a), 4);
    chk("wrong.ff", 32'(ff_a), 0);
    chk("wrong.pass", 32'(pass_a), 0);
    chk("model.wrong.err", m_err[0], 4);
    start_run(0, 0);
    chk("rerun.clr.err", 32'(err_a), 0);
    chk("rerun.clr.fv", 32'(fv_a), 0);
    wait_done(0, c);
    chk("rerun.pass", 32'(pass_a), 1);

    // saturation with zero settle
    gk[1] = 2;
    start_run(1, 3);
    wait_done(1, c);
    chk("sat.latency", c, 8);
    chk("sat.err", 32'(err_b), 3);
    chk("sat.ff", 32'(ff_b), 0);
    chk("sat.pass", 32'(pass_b), 0);
    chk("model.sat.err", m_err[1], 3);

    // ignored start, then abort
    start_run(0, 0);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort.busy", 32'(busy_a), 0);
    nd = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      if (done_a) nd++;
    end
    chk("abort.nodone", nd, 0);
    chk("abort.pass", 32'(pass_a), 0);

    // asynchronous reset mid-sweep
    stk[0] = 1;
    start_run(0, 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy_a), 0);
    chk("arst.stim", 32'(stim_a), 0);
    chk("arst.err", 32'(err_a), 0);
    chk("arst.fv", 32'(fv_a), 0);
    chk("arst.ff", 32'(ff_a), 0);
    chk("arst.done", 32'(done_a), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk[0] = 0;
    start_run(0, 0);
    wait_done(0, c);
    chk("arst.rerun.latency", c, 8);
    chk("arst.rerun.pass", 32'(pass_a), 1);

    // randomized sweeps: faults, function choice, stray starts, aborts
    for (int r = 0; r < 40; r++) begin
      n = int'($urandom_range(0, 1));
      gk[n] = int'($urandom_range(0, 3));
      stk[n] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      fen[n] = int'($urandom_range(0, 1));
      fvec[n] = int'($urandom_range(0, (1 << WW[n]) - 1));
      ab_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1;
      start_run(n, ($urandom_range(0, 1) == 0) ? gk[n] : int'($urandom_range(0, 3)));
      for (int t = 0; t < 40; t++) begin
        if ((n == 0 && !busy_a) || (n == 1 && !busy_b)) break;
        mode_a = 2'($urandom);
        mode_b = 2'($urandom);
        if (n == 0) begin
          start_a = ($urandom_range(0, 7) == 0);
          abort_a = (t == ab_at);
        end else begin
          start_b = ($urandom_range(0, 7) == 0);
          abort_b = (t == ab_at);
        end
        @(negedge clk);
      end
      start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
      repeat (20) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
